// File: rtl/scc_pkg.sv
// Shared constants for the instruction sequencer: FSM state encodings,
// special instruction words and instruction field positions.
package scc_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_EXEC  = 3'd3;
  localparam logic [2:0] S_WB    = 3'd4;
  localparam logic [2:0] S_HALT  = 3'd5;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 25;
  localparam int RD_MSB  = 24;
  localparam int RD_LSB  = 22;
  localparam int RN_MSB  = 21;
  localparam int RN_LSB  = 19;
  localparam int RM_MSB  = 18;
  localparam int RM_LSB  = 16;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  function automatic logic [6:0] instr_op(input logic [31:0] word);
    return word[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/seq_pc_counter.sv
// Word-addressed program counter: load to RESET_PC, increment with
// natural wrap-around, or hold.
module seq_pc_counter #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            inc,
  output logic [PC_W-1:0] pc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= RESET_PC;
    end else if (inc) begin
      pc <= pc + PC_W'(1);
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/execute/writeback controller in front of the ID -> Reg_File -> EXE
// datapath; holds each fetched word stable and commits it exactly once.
module instr_sequencer #(
  parameter int              PC_W      = 8,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter logic [31:0]     HALT_WORD = scc_pkg::HALT_WORD
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instruction,
  input  logic            id_write_enable,
  output logic            rf_write_enable,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            halted,
  output logic [31:0]     instr_count,
  output logic [2:0]      state
);
  import scc_pkg::*;

  // Memory handshake: imem_req stays high from S_FETCH through S_WAIT; a word
  // is accepted only on a cycle where state==S_WAIT and imem_valid==1.
  logic start_ok;
  logic pc_load;
  logic pc_inc;

  assign start_ok = start && (state == S_IDLE || state == S_HALT);
  assign pc_load  = start_ok;
  assign pc_inc   = (state == S_WB);

  seq_pc_counter #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk  (clk),
    .rst  (rst),
    .load (pc_load),
    .inc  (pc_inc),
    .pc   (pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      instruction <= NOP_WORD;
      instr_count <= 32'd0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            state       <= S_FETCH;
            instr_count <= 32'd0;
          end
        end
        S_FETCH: state <= S_WAIT;
        S_WAIT: begin
          if (imem_valid) begin
            instruction <= imem_rdata;
            state       <= S_EXEC;
          end
        end
        // The halt word is neither written back nor counted as retired.
        S_EXEC: state <= (instruction == HALT_WORD) ? S_HALT : S_WB;
        S_WB: begin
          instr_count <= instr_count + 32'd1;
          state       <= S_FETCH;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign imem_req        = (state == S_FETCH) || (state == S_WAIT);
  assign imem_addr       = pc;
  assign rf_write_enable = id_write_enable && (state == S_WB);
  assign busy            = (state == S_FETCH) || (state == S_WAIT) ||
                           (state == S_EXEC)  || (state == S_WB);
  assign halted          = (state == S_HALT);

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench: sequencer plus a behavioural ROM, ID/EXE decode and Reg_File,
// and a second narrow-PC instance for wrap-around.
module tb_instr_sequencer;
  import scc_pkg::*;

  localparam int PC_W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            imem_req, imem_valid, id_write_enable, rf_write_enable, busy, halted;
  logic [PC_W-1:0] imem_addr, pc;
  logic [31:0]     imem_rdata, instruction, instr_count;
  logic [2:0]      state;

  logic        b_start = 1'b0;
  logic        b_req, b_valid, b_id_we, b_rf_we, b_busy, b_halted;
  logic [1:0]  b_addr, b_pc;
  logic [31:0] b_rdata, b_instr, b_count;
  logic [2:0]  b_state;
  int          b_cnt;

  instr_sequencer #(.PC_W(PC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata), .instruction(instruction),
    .id_write_enable(id_write_enable), .rf_write_enable(rf_write_enable), .pc(pc),
    .busy(busy), .halted(halted), .instr_count(instr_count), .state(state)
  );

  instr_sequencer #(.PC_W(2)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .imem_req(b_req), .imem_addr(b_addr),
    .imem_valid(b_valid), .imem_rdata(b_rdata), .instruction(b_instr),
    .id_write_enable(b_id_we), .rf_write_enable(b_rf_we), .pc(b_pc),
    .busy(b_busy), .halted(b_halted), .instr_count(b_count), .state(b_state)
  );

  // ROM for the main instance: answers after rom_wait extra cycles; man_valid injects stray beats.
  logic [31:0] rom [4];
  int          rom_wait = 0;
  int          rom_cnt;
  logic        man_valid = 1'b0;
  logic [31:0] man_data = 32'h0;

  assign imem_rdata = man_valid ? man_data : rom[imem_addr[1:0]];
  assign imem_valid = man_valid | (imem_req && (rom_cnt >= rom_wait + 1));

  always @(posedge clk or posedge rst) begin
    if (rst) rom_cnt <= 0;
    else     rom_cnt <= (imem_req && !imem_valid) ? rom_cnt + 1 : 0;
  end

  assign b_rdata = 32'h2248_0001;
  assign b_id_we = 1'b1;
  assign b_valid = b_req && (b_cnt >= 1);

  always @(posedge clk or posedge rst) begin
    if (rst) b_cnt <= 0;
    else     b_cnt <= (b_req && !b_valid) ? b_cnt + 1 : 0;
  end

  // ID/EXE model: op 0 loads imm low, op 1 loads imm high, op 17 Rn+imm, op 49 Rn+Rm.
  logic [31:0] regs [8];
  logic        rf_clear = 1'b0;
  logic [6:0]  op;
  logic [2:0]  rd, rn, rm;
  logic [15:0] imm;
  logic [31:0] result;

  assign op  = instruction[31:25];
  assign rd  = instruction[24:22];
  assign rn  = instruction[21:19];
  assign rm  = instruction[18:16];
  assign imm = instruction[15:0];

  always_comb begin
    result          = 32'h0;
    id_write_enable = 1'b0;
    if (instruction != NOP_WORD && instruction != HALT_WORD) begin
      case (op)
        7'd0:  begin result = {regs[rd][31:16], imm}; id_write_enable = 1'b1; end
        7'd1:  begin result = {imm, regs[rd][15:0]};  id_write_enable = 1'b1; end
        7'd17: begin result = regs[rn] + {16'h0, imm}; id_write_enable = 1'b1; end
        7'd49: begin result = regs[rn] + regs[rm];     id_write_enable = 1'b1; end
        default: ;
      endcase
    end
  end

  always @(posedge clk) begin
    if (rf_clear) begin
      for (int i = 0; i < 8; i++) regs[i] <= 32'h0;
    end else if (rf_write_enable) begin
      regs[rd] <= result;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard of write data, sampled late in the cycle just before the write edge.
  logic [31:0] exp_q[$];
  int          we_cycles = 0;

  always @(negedge clk) begin
    #4;
    if (rf_write_enable) begin
      we_cycles++;
      if (exp_q.size() == 0) check("wr_unexpected", 32'(rf_write_enable), 32'd0);
      else                   check("wr_data", result, exp_q.pop_front());
    end
  end

  int          cyc = 0;
  int          wb_cyc[$];
  int          bad_changes = 0;
  logic [2:0]  prev_state = S_IDLE;
  logic [31:0] prev_instr = 32'h0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (instruction !== prev_instr && state != S_IDLE &&
        !(prev_state == S_WAIT && state == S_EXEC)) bad_changes++;
    if (state == S_WB && prev_state != S_WB) wb_cyc.push_back(cyc);
    prev_state = state;
    prev_instr = instruction;
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic clear_rf();
    rf_clear = 1'b1;
    @(negedge clk);
    rf_clear = 1'b0;
  endtask

  task automatic load_prog1();
    rom[0] = 32'h0000_FFFF;
    rom[1] = 32'h0200_EEEE;
    rom[2] = HALT_WORD;
    rom[3] = HALT_WORD;
  endtask

  task automatic wait_a_state(input logic [2:0] s, input string tag);
    int n = 0;
    while (state !== s && n < 300) begin @(negedge clk); n++; end
    if (state !== s) check(tag, 32'(state), 32'(s));
  endtask

  task automatic wait_b_count(input logic [31:0] c, input string tag);
    int n = 0;
    while (b_count !== c && n < 300) begin @(negedge clk); n++; end
    if (b_count !== c) check(tag, b_count, c);
  endtask

  initial begin
    int we0;
    int n;

    load_prog1();
    #1;
    check("rst_state", 32'(state), 32'(S_IDLE));
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_instr", instruction, 32'h0);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_rf_we", 32'(rf_write_enable), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_count", instr_count, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_release_we", 32'(rf_write_enable), 32'd0);
    check("idle_hold", 32'(state), 32'(S_IDLE));

    // Narrow PC: four non-halting words, pc wraps 3 -> 0.
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    wait_b_count(32'd4, "t4_timeout4");
    check("t4_pc_wrap", 32'(b_pc), 32'd0);
    n = 0;
    while (b_state !== S_FETCH && n < 20) begin @(negedge clk); n++; end
    check("t4_refetch_addr0", 32'(b_addr), 32'd0);
    check("t4_refetch_req", 32'(b_req), 32'd1);
    wait_b_count(32'd5, "t4_timeout5");
    check("t4_count5", b_count, 32'd5);
    check("t4_pc_after5", 32'(b_pc), 32'd1);

    // Two-instruction program, zero-wait memory.
    clear_rf();
    exp_q.push_back(32'h0000_FFFF);
    exp_q.push_back(32'hEEEE_FFFF);
    wb_cyc.delete();
    we0 = we_cycles;
    pulse_start();
    check("t1_busy", 32'(busy), 32'd1);
    wait_a_state(S_HALT, "t1_halt_timeout");
    check("t1_halted", 32'(halted), 32'd1);
    check("t1_pc", 32'(pc), 32'd2);
    check("t1_count", instr_count, 32'd2);
    check("t1_r0", regs[0], 32'hEEEE_FFFF);
    check("t1_we_cycles", 32'(we_cycles - we0), 32'd2);
    check("t1_wb_seen", 32'(wb_cyc.size()), 32'd2);
    if (wb_cyc.size() == 2) check("t1_period", 32'(wb_cyc[1] - wb_cyc[0]), 32'd4);

    // Three-instruction program with three extra wait cycles per fetch.
    load_prog1();
    rom[0] = 32'h0040_0001;
    rom[1] = 32'h2200_0001;
    rom[2] = 32'h6201_0000;
    rom[3] = HALT_WORD;
    rom_wait = 3;
    clear_rf();
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h2);
    wb_cyc.delete();
    pulse_start();
    wait_a_state(S_HALT, "t2_halt_timeout");
    check("t2_r0", regs[0], 32'h2);
    check("t2_r1", regs[1], 32'h1);
    check("t2_count", instr_count, 32'd3);
    check("t2_wb_seen", 32'(wb_cyc.size()), 32'd3);
    if (wb_cyc.size() == 3) begin
      check("t2_period0", 32'(wb_cyc[1] - wb_cyc[0]), 32'd7);
      check("t2_period1", 32'(wb_cyc[2] - wb_cyc[1]), 32'd7);
    end
    check("t2_instr_stable", 32'(bad_changes), 32'd0);
    rom_wait = 0;

    // Asynchronous reset during the second instruction's writeback.
    load_prog1();
    clear_rf();
    exp_q.push_back(32'h0000_FFFF);
    pulse_start();
    n = 0;
    while (!(state == S_WB && instr_count == 32'd1) && n < 100) begin @(negedge clk); n++; end
    check("t3_reach_wb2", 32'(state), 32'(S_WB));
    #1 rst = 1'b1;
    #1;
    check("t3_state", 32'(state), 32'(S_IDLE));
    check("t3_pc", 32'(pc), 32'd0);
    check("t3_rf_we", 32'(rf_write_enable), 32'd0);
    check("t3_req", 32'(imem_req), 32'd0);
    check("t3_busy", 32'(busy), 32'd0);
    check("t3_count", instr_count, 32'd0);
    check("t3_instr", instruction, NOP_WORD);
    @(negedge clk);
    check("t3_no_write", regs[0], 32'h0000_FFFF);
    rst = 1'b0;
    #1;
    check("t3_release_we", 32'(rf_write_enable), 32'd0);
    check("t3_q_drained", 32'(exp_q.size()), 32'd0);
    @(negedge clk);

    // start ignored mid-instruction, honoured in S_HALT.
    exp_q.push_back(32'h0000_FFFF);
    exp_q.push_back(32'hEEEE_FFFF);
    pulse_start();
    wait_a_state(S_WAIT, "t5_wait_timeout");
    pulse_start();
    check("t5_start_in_wait", 32'(state), 32'(S_EXEC));
    check("t5_pc_wait", 32'(pc), 32'd0);
    pulse_start();
    check("t5_start_in_exec", 32'(state), 32'(S_WB));
    wait_a_state(S_HALT, "t5_halt_timeout");
    check("t5_count", instr_count, 32'd2);
    exp_q.push_back(32'hEEEE_FFFF);
    exp_q.push_back(32'hEEEE_FFFF);
    pulse_start();
    check("t5_restart_state", 32'(state), 32'(S_FETCH));
    check("t5_restart_pc", 32'(pc), 32'd0);
    check("t5_restart_count", instr_count, 32'd0);
    wait_a_state(S_HALT, "t5_halt2_timeout");
    check("t5_count2", instr_count, 32'd2);

    // Stray imem_valid in S_IDLE and S_EXEC.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    man_data  = 32'h1234_5678;
    man_valid = 1'b1;
    @(negedge clk);
    man_valid = 1'b0;
    check("t6_idle_instr", instruction, 32'h0);
    check("t6_idle_state", 32'(state), 32'(S_IDLE));
    clear_rf();
    exp_q.push_back(32'h0000_FFFF);
    exp_q.push_back(32'hEEEE_FFFF);
    pulse_start();
    wait_a_state(S_EXEC, "t6_exec_timeout");
    man_valid = 1'b1;
    @(negedge clk);
    man_valid = 1'b0;
    check("t6_exec_instr", instruction, 32'h0000_FFFF);
    check("t6_exec_state", 32'(state), 32'(S_WB));
    wait_a_state(S_HALT, "t6_halt_timeout");
    check("t6_r0", regs[0], 32'hEEEE_FFFF);
    check("t6_q_drained", 32'(exp_q.size()), 32'd0);
    check("instr_stable_all", 32'(bad_changes), 32'd0);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
